// File: rtl/tpu_mac_dot_sched.sv
// Round-robin scheduler that time-shares one MAC among NUM_REQ dot-product requesters.
// Optional watchdog abort on a silent MAC is enabled by defining TPU_SCHED_TIMEOUT_EN.
module tpu_mac_dot_sched #(
    parameter int NUM_REQ     = 4,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len_i,
    input  logic [NUM_REQ*3-1:0]       req_dtype_i,
    output logic [NUM_REQ-1:0]         grant_o,
    input  logic                       op_valid_i,
    output logic                       op_ready_o,
    input  logic [15:0]                op_a_i,
    input  logic [15:0]                op_b_i,
    output logic                       done_valid_o,
    input  logic                       done_ready_i,
    output logic [31:0]                done_data_o,
    output logic [$clog2(NUM_REQ)-1:0] done_id_o,
    output logic                       done_err_o,
    output logic                       mac_enable_o,
    output logic [2:0]                 mac_dtype_o,
    output logic [15:0]                mac_a_o,
    output logic [15:0]                mac_b_o,
    output logic [31:0]                mac_c_o,
    output logic                       mac_valid_in_o,
    input  logic [31:0]                mac_result_i,
    input  logic                       mac_valid_out_i,
    input  logic                       mac_ready_i
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [2:0]         dtype_q, dtype_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic [31:0]        acc_q, acc_d;
    logic               done_valid_q, done_valid_d;
    logic [31:0]        done_data_q, done_data_d;

`ifdef TPU_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          done_err_q, done_err_d;
`endif

    // Rotating priority search: first requester at or after ptr_q, wrapping.
    logic           arb_found;
    logic [IDW-1:0] arb_sel;
    logic [IDW-1:0] cand;
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!arb_found && req_i[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    logic [LEN_W-1:0] sel_len;
    logic [2:0]       sel_dtype;
    assign sel_len   = req_len_i[int'(arb_sel)*LEN_W +: LEN_W];
    assign sel_dtype = req_dtype_i[int'(arb_sel)*3 +: 3];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        len_d        = len_q;
        count_d      = count_q;
        dtype_d      = dtype_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        done_valid_d = done_valid_q;
        done_data_d  = done_data_q;
`ifdef TPU_SCHED_TIMEOUT_EN
        tcnt_d       = tcnt_q;
        done_err_d   = done_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d          = '0;
                    grant_d[arb_sel] = 1'b1;
                    owner_d          = arb_sel;
                    ptr_d            = (int'(arb_sel) == NUM_REQ - 1) ? '0 : arb_sel + IDW'(1);
                    len_d            = sel_len;
                    dtype_d          = sel_dtype;
                    acc_d            = '0;
                    count_d          = '0;
                    // Empty jobs skip the MAC entirely and report a zero sum.
                    if (sel_len == '0) begin
                        state_d      = S_DONE;
                        done_valid_d = 1'b1;
                        done_data_d  = '0;
                    end else begin
                        state_d      = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (op_valid_i) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mac_ready_i) begin
                    state_d = S_WAIT;
`ifdef TPU_SCHED_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            S_WAIT: begin
                if (mac_valid_out_i) begin
                    acc_d   = mac_result_i;
                    count_d = count_q + LEN_W'(1);
                    if (count_q + LEN_W'(1) == len_q) begin
                        state_d      = S_DONE;
                        done_valid_d = 1'b1;
                        done_data_d  = mac_result_i;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
`ifdef TPU_SCHED_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d      = S_DONE;
                    done_valid_d = 1'b1;
                    done_data_d  = acc_q;
                    done_err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            S_DONE: begin
                // Grant is released here so the next arbitration starts from IDLE.
                if (done_ready_i) begin
                    state_d      = S_IDLE;
                    grant_d      = '0;
                    done_valid_d = 1'b0;
`ifdef TPU_SCHED_TIMEOUT_EN
                    done_err_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            ptr_q        <= '0;
            len_q        <= '0;
            count_q      <= '0;
            dtype_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            done_valid_q <= 1'b0;
            done_data_q  <= '0;
`ifdef TPU_SCHED_TIMEOUT_EN
            tcnt_q       <= '0;
            done_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            count_q      <= count_d;
            dtype_q      <= dtype_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            done_valid_q <= done_valid_d;
            done_data_q  <= done_data_d;
`ifdef TPU_SCHED_TIMEOUT_EN
            tcnt_q       <= tcnt_d;
            done_err_q   <= done_err_d;
`endif
        end
    end

    assign grant_o        = grant_q;
    assign op_ready_o     = (state_q == S_LOAD);
    assign done_valid_o   = done_valid_q;
    assign done_data_o    = done_data_q;
    assign done_id_o      = owner_q;
    assign mac_enable_o   = (state_q != S_IDLE);
    assign mac_dtype_o    = dtype_q;
    assign mac_a_o        = a_q;
    assign mac_b_o        = b_q;
    assign mac_c_o        = acc_q;
    assign mac_valid_in_o = (state_q == S_ISSUE) && mac_ready_i;
`ifdef TPU_SCHED_TIMEOUT_EN
    assign done_err_o     = done_err_q;
`else
    assign done_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_mac_dot_sched.sv
// Directed plus randomized bench for tpu_mac_dot_sched with a behavioural MAC and sum-of-products reference.
module tb_tpu_mac_dot_sched;
    localparam int N  = 4;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N*3-1:0]  req_dtype = '0;
    logic [N-1:0]    grant;
    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [15:0]     op_a = '0, op_b = '0;
    logic            done_valid;
    logic            done_ready = 1'b0;
    logic [31:0]     done_data;
    logic [1:0]      done_id;
    logic            done_err;
    logic            mac_enable;
    logic [2:0]      mac_dtype;
    logic [15:0]     mac_a, mac_b;
    logic [31:0]     mac_c;
    logic            mac_valid_in;
    logic [31:0]     mac_result = '0;
    logic            mac_valid_out = 1'b0;
    logic            mac_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int vin_cnt = 0, opr_cnt = 0, onehot_viol = 0;
    logic mac_stuck = 1'b0;
    logic rdy_rand = 1'b0;
    logic [15:0] qa[$], qb[$];

    tpu_mac_dot_sched #(.NUM_REQ(N), .LEN_W(LW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req), .req_len_i(req_len), .req_dtype_i(req_dtype),
        .grant_o(grant),
        .op_valid_i(op_valid), .op_ready_o(op_ready), .op_a_i(op_a), .op_b_i(op_b),
        .done_valid_o(done_valid), .done_ready_i(done_ready), .done_data_o(done_data),
        .done_id_o(done_id), .done_err_o(done_err),
        .mac_enable_o(mac_enable), .mac_dtype_o(mac_dtype), .mac_a_o(mac_a), .mac_b_o(mac_b),
        .mac_c_o(mac_c), .mac_valid_in_o(mac_valid_in),
        .mac_result_i(mac_result), .mac_valid_out_i(mac_valid_out), .mac_ready_i(mac_ready)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: unsigned multiply-accumulate, result one cycle after valid_in.
    always @(posedge clk) begin
        mac_valid_out <= mac_valid_in && !mac_stuck;
        mac_result    <= mac_c + ((mac_dtype == 3'b000) ? ({24'd0, mac_a[7:0]} * {24'd0, mac_b[7:0]})
                                                        : ({16'd0, mac_a} * {16'd0, mac_b}));
    end

    always @(posedge clk) begin
        #1;
        mac_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (mac_valid_in) vin_cnt++;
        if (op_ready) opr_cnt++;
        if (!$onehot0(grant)) onehot_viol++;
    end

    function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b, input logic [2:0] dt);
        if (dt == 3'b000) return 32'(a[7:0]) * 32'(b[7:0]);
        return 32'(a) * 32'(b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int id, input int len, input logic [2:0] dt);
        req_len[id*LW +: LW] = LW'(len);
        req_dtype[id*3 +: 3] = dt;
        req[id]              = 1'b1;
    endtask

    task automatic fill(input int len);
        qa.delete();
        qb.delete();
        for (int i = 0; i < len; i++) begin
            qa.push_back(16'($urandom));
            qb.push_back(16'($urandom));
        end
    endtask

    task automatic get_grant(output int id, output int waited);
        id     = -1;
        waited = 0;
        while (grant == '0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        for (int k = 0; k < N; k++) if (grant[k]) id = k;
        chk("grant_seen", (id >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Feeds the granted job's operands from qa/qb, then checks and consumes the result.
    task automatic serve(input int id, input int len, input logic [2:0] dt, input bit hold,
                         output logic [31:0] got);
        logic [31:0] exp_sum;
        int idx, cyc, v0;
        exp_sum = 0;
        for (int i = 0; i < len; i++) exp_sum += prod(qa[i], qb[i], dt);
        v0  = vin_cnt;
        idx = 0;
        cyc = 0;
        while (!done_valid && cyc < 300) begin
            if (op_ready && idx < len && $urandom_range(0, 3) != 0) begin
                op_valid = 1'b1;
                op_a     = qa[idx];
                op_b     = qb[idx];
                idx++;
            end else begin
                op_valid = 1'b0;
                op_a     = 16'($urandom);
                op_b     = 16'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        op_valid = 1'b0;
        got      = done_data;
        chk("done_arrived", 32'(done_valid), 32'd1);
        chk("done_data", done_data, exp_sum);
        chk("done_id", 32'(done_id), 32'(id));
        chk("done_err", 32'(done_err), 32'd0);
        chk("mac_pulses", 32'(vin_cnt - v0), 32'(len));
        chk("ops_taken", 32'(idx), 32'(len));
        chk("grant_held", 32'(grant), 32'(1 << id));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("hold_valid", 32'(done_valid), 32'd1);
                chk("hold_data", done_data, exp_sum);
                chk("hold_id", 32'(done_id), 32'(id));
                chk("hold_grant", 32'(grant), 32'(1 << id));
            end
        end
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        chk("release_valid", 32'(done_valid), 32'd0);
        chk("release_grant", 32'(grant), 32'd0);
    endtask

    initial begin
        int id, w, o0, pulses, wait_cyc;
        logic [31:0] got;

        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ctl", {26'd0, op_ready, done_valid, done_err, mac_enable, mac_valid_in, 1'b0}, 32'd0);
        chk("rst_done", done_data | 32'(done_id), 32'd0);
        chk("rst_mac", mac_c | 32'(mac_a) | 32'(mac_b) | 32'(mac_dtype), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic INT16 dot product.
        qa = '{16'd2, 16'd3, 16'd4};
        qb = '{16'd5, 16'd6, 16'd7};
        post(0, 3, 3'b001);
        get_grant(id, w);
        req[0] = 1'b0;
        chk("t1_id", 32'(id), 32'd0);
        serve(0, 3, 3'b001, 1'b0, got);
        chk("t1_sum", got, 32'd56);

        // Wraparound and INT8 operand truncation.
        qa = '{16'hFFFF, 16'hFFFF};
        qb = '{16'hFFFF, 16'hFFFF};
        post(1, 2, 3'b001);
        get_grant(id, w);
        req[1] = 1'b0;
        serve(1, 2, 3'b001, 1'b0, got);
        chk("t4_wrap", got, 32'hFFFC0002);
        qa = '{16'h01FF};
        qb = '{16'h0002};
        post(2, 1, 3'b000);
        get_grant(id, w);
        req[2] = 1'b0;
        serve(2, 1, 3'b000, 1'b0, got);
        chk("t4_int8", got, 32'd510);

        // Zero-length job.
        o0 = opr_cnt;
        qa.delete();
        qb.delete();
        post(1, 0, 3'b000);
        get_grant(id, w);
        req[1] = 1'b0;
        chk("t3_lat", (w <= 2 && done_valid) ? 32'd1 : 32'd0, 32'd1);
        serve(1, 0, 3'b000, 1'b0, got);
        chk("t3_sum", got, 32'd0);
        chk("t3_no_ready", 32'(opr_cnt - o0), 32'd0);

        // Result backpressure.
        fill(4);
        post(2, 4, 3'b010);
        get_grant(id, w);
        req[2] = 1'b0;
        serve(2, 4, 3'b010, 1'b1, got);

        // Randomized single-requester jobs with MAC ready stalls.
        rdy_rand = 1'b1;
        for (int j = 0; j < 12; j++) begin
            int rid, rlen;
            logic [2:0] rdt;
            rid  = $urandom_range(0, N - 1);
            rlen = $urandom_range(0, 6);
            rdt  = 3'($urandom_range(0, 2));
            fill(rlen);
            post(rid, rlen, rdt);
            get_grant(id, w);
            req[rid] = 1'b0;
            chk("rand_id", 32'(id), 32'(rid));
            serve(rid, rlen, rdt, 1'b0, got);
        end
        rdy_rand = 1'b0;
        @(negedge clk);

        // Round-robin order with all requesters held from reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) post(k, 1, 3'b001);
        for (int j = 0; j < 5; j++) begin
            get_grant(id, w);
            chk("t2_order", 32'(id), 32'(j % N));
            if (j == 4) req = '0;
            fill(1);
            serve(id, 1, 3'b001, 1'b0, got);
        end
        chk("t2_onehot", 32'(onehot_viol), 32'd0);

        // Reset while waiting on the MAC for element two of three.
        fill(3);
        post(2, 3, 3'b000);
        get_grant(id, w);
        req[2] = 1'b0;
        pulses   = 0;
        wait_cyc = 0;
        while (pulses < 2 && wait_cyc < 60) begin
            if (mac_valid_in) pulses++;
            if (pulses < 2) begin
                op_valid = op_ready;
                op_a     = qa[pulses];
                op_b     = qb[pulses];
                @(negedge clk);
            end
            wait_cyc++;
        end
        op_valid = 1'b0;
        @(negedge clk);
        chk("t6_in_wait", {30'd0, mac_enable, op_ready}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", {27'd0, op_ready, done_valid, mac_enable, mac_valid_in, 1'b0}, 32'd0);
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_acc", mac_c, 32'd0);
        @(posedge clk);
        #1;
        chk("t6_rst_hold", {27'd0, op_ready, done_valid, mac_enable, mac_valid_in, 1'b0} | 32'(grant), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fill(2);
        post(3, 2, 3'b010);
        get_grant(id, w);
        req[3] = 1'b0;
        chk("t6_id", 32'(id), 32'd3);
        serve(3, 2, 3'b010, 1'b0, got);

`ifdef TPU_SCHED_TIMEOUT_EN
        // Watchdog abort with a MAC that never answers.
        mac_stuck = 1'b1;
        fill(2);
        post(1, 2, 3'b001);
        get_grant(id, w);
        req[1]   = 1'b0;
        wait_cyc = 0;
        pulses   = 0;
        while (!done_valid && pulses < 100) begin
            op_valid = op_ready;
            op_a     = qa[0];
            op_b     = qb[0];
            if (mac_enable && !op_ready && !mac_valid_in) wait_cyc++;
            @(negedge clk);
            pulses++;
        end
        op_valid = 1'b0;
        chk("to_err", 32'(done_err), 32'd1);
        chk("to_data", done_data, 32'd0);
        chk("to_wait_cyc", 32'(wait_cyc), 32'd16);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        mac_stuck  = 1'b0;
        chk("to_err_clr", 32'(done_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
